// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_arb_pkg
//  Purpose  : Shared types and constants for the MAC transmit frame arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package eth_tx_arb_pkg;

   // Arbiter frame-level state
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // Data byte carried by the forced end-of-frame beat after a starvation timeout
   localparam logic [7:0] TERM_DATA = 8'h00;

   // Width of each per-channel completed-frame counter
   localparam int STAT_W = 32;

endpackage : eth_tx_arb_pkg
`default_nettype wire

// File: rtl/eth_mac_tx_frame_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin picker. Searches the request vector
//             starting one position after the last grant, wrapping around,
//             and returns the first requester found.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter  int CHANNELS = 4,
   localparam int CH_W     = $clog2(CHANNELS)
)(
   input  logic [CHANNELS-1:0] req,
   input  logic [CH_W-1:0]     last_grant,
   output logic [CH_W-1:0]     grant,
   output logic                grant_valid
);

   // Scan from last_grant+1 upward; the first hit wins and later hits are ignored
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = 1; k <= CHANNELS; k++) begin
         if (!grant_valid && req[(int'(last_grant) + k) % CHANNELS]) begin
            grant       = CH_W'((int'(last_grant) + k) % CHANNELS);
            grant_valid = 1'b1;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/eth_mac_tx_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module   : eth_mac_tx_frame_arb
//  Purpose  : Frame-level round-robin merge of CHANNELS byte-wide AXI-stream
//             sources onto the 1G MAC transmit input (tx_clk domain). Frames
//             are never interleaved. A source that starves mid-frame for
//             TIMEOUT_CYCLES is cut off: the output frame is closed with a bad
//             terminator beat and the rest of the source frame is discarded.
//  Options  : ETH_TX_FRAME_ARB_STATS_EN - per-channel completed-frame counters
//             on stat_frames (tied to zero when undefined).
//  Revision : 1.0  initial release
// ============================================================================
module eth_mac_tx_frame_arb
   import eth_tx_arb_pkg::*;
#(
   parameter  int CHANNELS       = 4,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int CH_W           = $clog2(CHANNELS)
)(
   input  logic                       tx_clk,
   input  logic                       tx_rst,
   input  logic [CHANNELS*8-1:0]      s_axis_tdata,
   input  logic [CHANNELS-1:0]        s_axis_tvalid,
   output logic [CHANNELS-1:0]        s_axis_tready,
   input  logic [CHANNELS-1:0]        s_axis_tlast,
   input  logic [CHANNELS-1:0]        s_axis_tuser,
   output logic [7:0]                 m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   input  logic [CHANNELS-1:0]        cfg_ch_enable,
   output logic                       status_active,
   output logic [CH_W-1:0]            status_channel,
   output logic [CHANNELS-1:0]        status_timeout,
   output logic [CHANNELS*STAT_W-1:0] stat_frames
);

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
   localparam bit         TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

   arb_state_t          state;
   arb_state_t          state_next;
   logic [CH_W-1:0]     grant;
   logic [CH_W-1:0]     last_ptr;
   logic [7:0]          idle_cnt;
   logic [CHANNELS-1:0] req;
   logic [CH_W-1:0]     rr_grant;
   logic                rr_valid;
   logic                out_free;
   logic                sel_valid;
   logic                sel_last;
   logic                sel_user;
   logic [7:0]          sel_data;
   logic                load_beat;
   logic                load_term;
   logic                frame_done;

   // Only enabled channels with data pending compete for the next grant
   assign req = s_axis_tvalid & cfg_ch_enable;

   rr_arbiter #(
      .CHANNELS    (CHANNELS)
   ) u_rr (
      .req         (req),
      .last_grant  (last_ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   // The output stage can take a new beat when empty or being drained this cycle
   assign out_free = !m_axis_tvalid || m_axis_tready;

   assign sel_valid = s_axis_tvalid[grant];
   assign sel_last  = s_axis_tlast[grant];
   assign sel_user  = s_axis_tuser[grant];
   assign sel_data  = s_axis_tdata[8*grant +: 8];

   assign status_active  = (state != IDLE);
   assign status_channel = grant;

   // Frame FSM state register
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) state <= IDLE;
      else        state <= state_next;
   end

   // Next state, source handshake and output-stage load decisions
   always_comb begin
      state_next    = state;
      s_axis_tready = '0;
      load_beat     = 1'b0;
      load_term     = 1'b0;
      frame_done    = 1'b0;
      case (state)
         IDLE: begin
            if (rr_valid) state_next = XFER;
         end
         XFER: begin
            s_axis_tready[grant] = out_free;
            if (sel_valid && out_free) begin
               // A real beat always beats the timeout, even on the same cycle
               load_beat = 1'b1;
               if (sel_last) begin
                  frame_done = 1'b1;
                  state_next = IDLE;
               end
            end else if (TIMEOUT_EN && (idle_cnt == TIMEOUT_VAL) && out_free) begin
               load_term  = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            s_axis_tready[grant] = 1'b1;
            if (sel_valid && sel_last) begin
               frame_done = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Grant capture at arbitration and round-robin pointer update at frame end
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         grant    <= '0;
         last_ptr <= CH_W'(CHANNELS - 1);
      end else begin
         if (state == IDLE && rr_valid) grant <= rr_grant;
         if (frame_done)                last_ptr <= grant;
      end
   end

   // Starvation counter: counts free output cycles with no source data, saturating
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         idle_cnt <= '0;
      end else if (state != XFER || load_beat) begin
         idle_cnt <= '0;
      end else if (!sel_valid && out_free && idle_cnt != TIMEOUT_VAL) begin
         idle_cnt <= idle_cnt + 8'd1;
      end
   end

   // Single output register stage toward the MAC
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (load_beat) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= sel_data;
         m_axis_tlast  <= sel_last;
         m_axis_tuser  <= sel_user;
      end else if (load_term) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= TERM_DATA;
         m_axis_tlast  <= 1'b1;
         m_axis_tuser  <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end
   end

   // One-cycle flag on the channel whose frame was forcibly closed
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst)         status_timeout <= '0;
      else if (load_term) status_timeout <= {{(CHANNELS-1){1'b0}}, 1'b1} << grant;
      else                status_timeout <= '0;
   end

`ifdef ETH_TX_FRAME_ARB_STATS_EN
   for (genvar i = 0; i < CHANNELS; i++) begin : g_stat
      logic [STAT_W-1:0] frame_cnt;

      // Count every completed source frame of this channel, timed-out ones included
      always_ff @(posedge tx_clk or posedge tx_rst) begin
         if (tx_rst)                                 frame_cnt <= '0;
         else if (frame_done && grant == CH_W'(i))   frame_cnt <= frame_cnt + 1'b1;
      end

      assign stat_frames[STAT_W*i +: STAT_W] = frame_cnt;
   end
`else
   assign stat_frames = '0;
`endif

endmodule : eth_mac_tx_frame_arb
`default_nettype wire

// File: tb/tb_eth_mac_tx_frame_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_mac_tx_frame_arb
//  Purpose  : Scoreboard bench for the MAC transmit frame arbiter. Directed
//             source frames push expected output beats into a queue; a
//             monitor pops and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_mac_tx_frame_arb;

   localparam int CH   = 4;
   localparam int TO   = 16;
   localparam int CH_W = $clog2(CH);

   logic              tx_clk = 1'b0;
   logic              tx_rst;
   logic [CH*8-1:0]   s_axis_tdata;
   logic [CH-1:0]     s_axis_tvalid;
   logic [CH-1:0]     s_axis_tready;
   logic [CH-1:0]     s_axis_tlast;
   logic [CH-1:0]     s_axis_tuser;
   logic [7:0]        m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic              m_axis_tuser;
   logic [CH-1:0]     cfg_ch_enable;
   logic              status_active;
   logic [CH_W-1:0]   status_channel;
   logic [CH-1:0]     status_timeout;
   logic [CH*32-1:0]  stat_frames;

   logic [7:0] d [CH];
   logic       v [CH];
   logic       l [CH];
   logic       u [CH];

   for (genvar g = 0; g < CH; g++) begin : g_drv
      assign s_axis_tdata[8*g +: 8] = d[g];
      assign s_axis_tvalid[g]       = v[g];
      assign s_axis_tlast[g]        = l[g];
      assign s_axis_tuser[g]        = u[g];
   end

   eth_mac_tx_frame_arb #(
      .CHANNELS       (CH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .tx_clk         (tx_clk),
      .tx_rst         (tx_rst),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tuser   (s_axis_tuser),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tuser   (m_axis_tuser),
      .cfg_ch_enable  (cfg_ch_enable),
      .status_active  (status_active),
      .status_channel (status_channel),
      .status_timeout (status_timeout),
      .stat_frames    (stat_frames)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   beat_t exp_q [$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc   = 0;
   int    first_out_cyc = -1;
   int    to_cnt [CH];
   int    exp_frames [CH];
   int    stray = 0;
   bit    stray_watch = 1'b0;
   int    tr_mode = 0;   // 0: ready high, 1: toggle each cycle, 2: ready low

   always #5 tx_clk = ~tx_clk;

   initial forever begin
      @(posedge tx_clk);
      cyc++;
   end

   // Sink ready pattern, changed just after each rising edge
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge tx_clk);
         #1;
         case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: compare every output handshake against the scoreboard
   initial forever begin
      @(negedge tx_clk);
      if (!tx_rst) begin
         if (m_axis_tvalid && m_axis_tready) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL beat: unexpected output data=%h last=%b user=%b, required no beat",
                        m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
                  n_err++;
                  $display("FAIL beat: got data=%h last=%b user=%b required data=%h last=%b user=%b",
                           m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
               end
            end
         end
         for (int i = 0; i < CH; i++) begin
            if (status_timeout[i]) to_cnt[i]++;
            if (stray_watch && i != 0 && s_axis_tready[i]) stray++;
         end
      end
   end

   task automatic expect_frame(input int n, input logic [7:0] base, input bit last_end, input bit user);
      for (int b = 0; b < n; b++) begin
         beat_t e;
         e.data = base + 8'(b);
         e.last = last_end && (b == n - 1);
         e.user = user;
         exp_q.push_back(e);
      end
   endtask

   // Present n beats on one channel, each held until the arbiter accepts it
   task automatic send_beats(input int ch, input int n, input logic [7:0] base,
                             input bit last_end, input bit user);
      for (int b = 0; b < n; b++) begin
         int w;
         d[ch] = base + 8'(b);
         v[ch] = 1'b1;
         l[ch] = last_end && (b == n - 1);
         u[ch] = user;
         w = 0;
         forever begin
            @(negedge tx_clk);
            if (s_axis_tready[ch]) break;
            w++;
            if (w > 2000) break;
         end
         if (w > 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_wait: ch%0d beat %0d not accepted within 2000 cycles, required acceptance", ch, b);
         end
         @(posedge tx_clk);
         #1;
      end
      v[ch] = 1'b0;
      l[ch] = 1'b0;
      u[ch] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || status_active) && k < 1000) begin
         @(posedge tx_clk);
         k++;
      end
      #1;
      chk(name, 64'(k < 1000), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         d[i] = '0; v[i] = 1'b0; l[i] = 1'b0; u[i] = 1'b0;
         to_cnt[i] = 0; exp_frames[i] = 0;
      end
      cfg_ch_enable = 4'hF;
      tx_rst = 1'b1;
      repeat (3) @(posedge tx_clk);
      #1;
      chk("reset_outputs",
          {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, status_active,
           status_channel, status_timeout, s_axis_tready}, 64'd0);
      chk("reset_stats", stat_frames[63:0] | stat_frames[127:64], 64'd0);
      tx_rst = 1'b0;
      @(posedge tx_clk);
      #1;

      // Single 5-byte frame on channel 0, first output two cycles after valid
      begin
         int t0;
         expect_frame(5, 8'h10, 1'b1, 1'b0);
         exp_frames[0]++;
         first_out_cyc = -1;
         t0 = cyc;
         send_beats(0, 5, 8'h10, 1'b1, 1'b0);
         wait_idle("t1_done");
         chk("t1_latency", 64'(first_out_cyc - t0), 64'd2);
         chk("t1_channel", 64'(status_channel), 64'd0);
      end

      // Channels 1 and 3 contend: whole frames alternate 1,3,1,3
      expect_frame(3, 8'h20, 1'b1, 1'b0);
      expect_frame(3, 8'h30, 1'b1, 1'b1);
      expect_frame(3, 8'h23, 1'b1, 1'b0);
      expect_frame(3, 8'h33, 1'b1, 1'b0);
      exp_frames[1] += 2;
      exp_frames[3] += 2;
      fork
         begin
            send_beats(1, 3, 8'h20, 1'b1, 1'b0);
            send_beats(1, 3, 8'h23, 1'b1, 1'b0);
         end
         begin
            send_beats(3, 3, 8'h30, 1'b1, 1'b1);
            send_beats(3, 3, 8'h33, 1'b1, 1'b0);
         end
      join
      wait_idle("t2_done");
      chk("t2_channel", 64'(status_channel), 64'd3);

      // Channel 2 starves mid-frame: terminator beat, then remainder drained
      expect_frame(2, 8'h40, 1'b0, 1'b0);
      expect_frame(1, 8'h00, 1'b1, 1'b1);
      exp_frames[2]++;
      send_beats(2, 2, 8'h40, 1'b0, 1'b0);
      repeat (30) @(posedge tx_clk);
      #1;
      chk("t3_in_drain", 64'({status_active, exp_q.size() == 0}), 64'd3);
      send_beats(2, 4, 8'h42, 1'b1, 1'b0);
      wait_idle("t3_done");
      chk("t3_timeout_ch2", 64'(to_cnt[2]), 64'd1);
      chk("t3_timeout_other", 64'(to_cnt[0] + to_cnt[1] + to_cnt[3]), 64'd0);

      // 64-byte frame with sink ready toggling every cycle
      tr_mode = 1;
      expect_frame(64, 8'h80, 1'b1, 1'b0);
      exp_frames[0]++;
      send_beats(0, 64, 8'h80, 1'b1, 1'b0);
      wait_idle("t4_done");
      tr_mode = 0;
      repeat (2) @(posedge tx_clk);
      #1;

      // Only channel 0 enabled; its enable drops mid-frame
      cfg_ch_enable = 4'b0001;
      for (int i = 1; i < CH; i++) begin
         d[i] = 8'hE0 + 8'(i); v[i] = 1'b1; l[i] = 1'b0; u[i] = 1'b0;
      end
      stray = 0;
      stray_watch = 1'b1;
      expect_frame(6, 8'h50, 1'b1, 1'b0);
      exp_frames[0]++;
      fork
         send_beats(0, 6, 8'h50, 1'b1, 1'b0);
         begin
            repeat (4) @(posedge tx_clk);
            #2;
            cfg_ch_enable = 4'b0000;
         end
      join
      repeat (20) @(posedge tx_clk);
      #1;
      chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("t5_idle", 64'(status_active), 64'd0);
      chk("t5_no_stray", 64'(stray), 64'd0);
      chk("t5_channel", 64'(status_channel), 64'd0);
      stray_watch = 1'b0;
      for (int i = 1; i < CH; i++) v[i] = 1'b0;
      cfg_ch_enable = 4'hF;

`ifdef ETH_TX_FRAME_ARB_STATS_EN
      for (int i = 0; i < CH; i++)
         chk($sformatf("stat_frames_ch%0d", i), 64'(stat_frames[32*i +: 32]), 64'(exp_frames[i]));
`endif

      // Asynchronous reset while a beat is parked in the output register
      tr_mode = 2;
      @(posedge tx_clk);
      #1;
      d[3] = 8'h99; v[3] = 1'b1; l[3] = 1'b0; u[3] = 1'b0;
      begin
         int k;
         k = 0;
         while (!m_axis_tvalid && k < 10) begin
            @(negedge tx_clk);
            k++;
         end
      end
      chk("pre_reset_beat", {m_axis_tvalid, m_axis_tdata, status_active, status_channel},
          {1'b1, 8'h99, 1'b1, 2'd3});
      @(negedge tx_clk);
      #2;
      tx_rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, status_active,
           status_channel, status_timeout, s_axis_tready}, 64'd0);
      chk("async_reset_stats", stat_frames[63:0] | stat_frames[127:64], 64'd0);
      v[3] = 1'b0;
      repeat (2) @(posedge tx_clk);
      #1;
      tx_rst = 1'b0;
      tr_mode = 0;
      repeat (2) @(posedge tx_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

endmodule : tb_eth_mac_tx_frame_arb
`default_nettype wire
